// File: rtl/tcp_tx_frame_gen_if.sv
// Bundle of the SiTCP TCP transmit port and the generator control/status lines.
// master = generator side, slave = SiTCP/controller side.
interface tcp_tx_frame_gen_if #(
  parameter int LEN_W = 16
);
  logic             TCP_OPEN_ACK;
  logic             TCP_TX_FULL;
  logic             GEN_START;
  logic             GEN_STOP;
  logic             GEN_CONT;
  logic [LEN_W-1:0] GEN_LEN;
  logic             TCP_TX_WR;
  logic [7:0]       TCP_TX_DATA;
  logic             GEN_BUSY;
  logic [31:0]      FRAME_CNT;

  modport master (
    input  TCP_OPEN_ACK, TCP_TX_FULL, GEN_START, GEN_STOP, GEN_CONT, GEN_LEN,
    output TCP_TX_WR, TCP_TX_DATA, GEN_BUSY, FRAME_CNT
  );

  modport slave (
    output TCP_OPEN_ACK, TCP_TX_FULL, GEN_START, GEN_STOP, GEN_CONT, GEN_LEN,
    input  TCP_TX_WR, TCP_TX_DATA, GEN_BUSY, FRAME_CNT
  );
endinterface

// File: rtl/tcp_tx_frame_gen.sv
// Framed test-pattern source for the SiTCP TCP TX port:
// header, 32-bit big-endian sequence, incrementing payload, XOR checksum.
module tcp_tx_frame_gen #(
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         LEN_W    = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  tcp_tx_frame_gen_if.master         bus
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_PAY, S_CSUM, S_GAP} state_t;

  state_t           r_state;
  logic [1:0]       r_seq_idx;
  logic [LEN_W-1:0] r_pay_idx;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_seq;
  logic [7:0]       r_csum;
  logic             r_stop_pend;
  logic             r_wr;
  logic [7:0]       r_data;
  logic             r_busy;
  logic [31:0]      r_frame_cnt;

  logic [7:0]       w_byte;
  logic             w_emit;

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      S_HDR:  w_byte = HDR_BYTE;
      S_SEQ: begin
        case (r_seq_idx)
          2'd0:    w_byte = r_seq[31:24];
          2'd1:    w_byte = r_seq[23:16];
          2'd2:    w_byte = r_seq[15:8];
          default: w_byte = r_seq[7:0];
        endcase
      end
      S_PAY:  w_byte = r_pay_idx[7:0];
      S_CSUM: w_byte = r_csum;
      default: w_byte = 8'h00;
    endcase
  end

  assign w_emit = (r_state == S_HDR || r_state == S_SEQ || r_state == S_PAY || r_state == S_CSUM)
                  && !bus.TCP_TX_FULL;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_seq_idx   <= 2'd0;
      r_pay_idx   <= '0;
      r_len       <= '0;
      r_seq       <= 32'd0;
      r_csum      <= 8'h00;
      r_stop_pend <= 1'b0;
      r_wr        <= 1'b0;
      r_data      <= 8'h00;
      r_busy      <= 1'b0;
      r_frame_cnt <= 32'd0;
    end else if (!bus.TCP_OPEN_ACK) begin
      // Losing the connection abandons the frame and restarts the sequence at 0.
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_busy      <= 1'b0;
      r_seq       <= 32'd0;
      r_stop_pend <= 1'b0;
    end else begin
      r_wr <= w_emit;
      if (w_emit) r_data <= w_byte;
      if (bus.GEN_STOP && r_state != S_IDLE) r_stop_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.GEN_START) begin
            r_state <= S_HDR;
            r_len   <= bus.GEN_LEN;
            r_busy  <= 1'b1;
          end
        end
        S_HDR: begin
          if (w_emit) begin
            r_csum    <= HDR_BYTE;
            r_seq_idx <= 2'd0;
            r_state   <= S_SEQ;
          end
        end
        S_SEQ: begin
          if (w_emit) begin
            r_csum    <= r_csum ^ w_byte;
            r_seq_idx <= r_seq_idx + 2'd1;
            if (r_seq_idx == 2'd3) begin
              r_pay_idx <= '0;
              r_state   <= (r_len == '0) ? S_CSUM : S_PAY;
            end
          end
        end
        S_PAY: begin
          if (w_emit) begin
            r_csum    <= r_csum ^ w_byte;
            r_pay_idx <= r_pay_idx + LEN_W'(1);
            if (r_pay_idx == r_len - LEN_W'(1)) r_state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (w_emit) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
            r_seq       <= r_seq + 32'd1;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          // A stop arriving in the gap cycle itself also ends the run.
          if (bus.GEN_CONT && !r_stop_pend && !bus.GEN_STOP) begin
            r_state <= S_HDR;
            r_len   <= bus.GEN_LEN;
          end else begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_stop_pend <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.TCP_TX_WR   = r_wr;
  assign bus.TCP_TX_DATA = r_data;
  assign bus.GEN_BUSY    = r_busy;
  assign bus.FRAME_CNT   = r_frame_cnt;

endmodule

// File: tb/tb_tcp_tx_frame_gen.sv
// Self-checking bench for tcp_tx_frame_gen: captured write stream compared with a frame-level model.
module tb_tcp_tx_frame_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tcp_tx_frame_gen_if #(.LEN_W(16)) bus();

  tcp_tx_frame_gen #(.HDR_BYTE(8'hA5), .LEN_W(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  logic [7:0]  cap[$];
  int          capt[$];
  logic [7:0]  exp_q[$];
  logic [31:0] m_seq;
  logic [31:0] m_cnt;
  bit          busy_seen;
  bit          rnd_full;

  typedef struct {
    int         len;
    logic [7:0] csum;
    int         nbytes;
  } vec_t;
  vec_t tbl[5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.TCP_TX_WR === 1'b1) begin
      cap.push_back(bus.TCP_TX_DATA);
      capt.push_back(cyc);
    end
    if (bus.GEN_BUSY === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_full) bus.TCP_TX_FULL = ($urandom_range(0, 2) == 0);
  endtask

  // Reference frame: header, big-endian seq, i mod 256 payload, XOR of all preceding bytes.
  task automatic push_frame(input int len);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int k = 3; k >= 0; k--) begin
      b = m_seq[8*k +: 8];
      exp_q.push_back(b);
      cs = cs ^ b;
    end
    for (int i = 0; i < len; i++) begin
      b = 8'(i % 256);
      exp_q.push_back(b);
      cs = cs ^ b;
    end
    exp_q.push_back(cs);
    m_seq = m_seq + 32'd1;
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic clear();
    cap.delete();
    capt.delete();
    exp_q.delete();
    busy_seen = 1'b0;
  endtask

  task automatic pulse_start();
    bus.GEN_START = 1'b1;
    tick();
    bus.GEN_START = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 5000 && bus.GEN_BUSY; k++) tick();
    if (bus.GEN_BUSY) chk({nm, " idle timeout"}, 1, 0);
    tick();
  endtask

  task automatic wait_cap(input int n, input string nm);
    for (int k = 0; k < 2000 && cap.size() < n; k++) tick();
    if (cap.size() < n) chk({nm, " capture timeout"}, cap.size(), n);
  endtask

  task automatic cmp_frames(input string nm);
    int mism;
    int n;
    mism = 0;
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    chk({nm, " byte count"}, cap.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) mism++;
    chk({nm, " byte mismatches"}, mism, 0);
    chk({nm, " frame count"}, bus.FRAME_CNT, m_cnt);
  endtask

  initial begin
    int n;
    tbl[0] = '{len: 3, csum: 8'hA6, nbytes: 9};
    tbl[1] = '{len: 0, csum: 8'hA4, nbytes: 6};
    tbl[2] = '{len: 1, csum: 8'hA7, nbytes: 7};
    tbl[3] = '{len: 4, csum: 8'hA6, nbytes: 10};
    tbl[4] = '{len: 2, csum: 8'hA0, nbytes: 8};

    rnd_full = 1'b0;
    rst = 1'b1;
    bus.TCP_OPEN_ACK = 1'b0;
    bus.TCP_TX_FULL  = 1'b0;
    bus.GEN_START    = 1'b0;
    bus.GEN_STOP     = 1'b0;
    bus.GEN_CONT     = 1'b0;
    bus.GEN_LEN      = 16'd0;
    m_seq = 32'd0;
    m_cnt = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset wr", bus.TCP_TX_WR, 0);
    chk("reset data", bus.TCP_TX_DATA, 0);
    chk("reset busy", bus.GEN_BUSY, 0);
    chk("reset frame_cnt", bus.FRAME_CNT, 0);

    bus.TCP_OPEN_ACK = 1'b1;
    tick();

    // Single frames from the vector table (seq increments row by row).
    for (int i = 0; i < 5; i++) begin
      clear();
      bus.GEN_LEN  = 16'(tbl[i].len);
      bus.GEN_CONT = 1'b0;
      pulse_start();
      wait_idle("table");
      push_frame(tbl[i].len);
      chk($sformatf("table%0d nbytes", i), cap.size(), tbl[i].nbytes);
      chk($sformatf("table%0d csum", i), (cap.size() > 0) ? cap[cap.size()-1] : 8'h00, tbl[i].csum);
      chk($sformatf("table%0d contiguous", i),
          (capt.size() > 0) ? capt[capt.size()-1] - capt[0] : -1, tbl[i].nbytes - 1);
      cmp_frames($sformatf("table%0d", i));
    end

    // Continuous 6-byte frames, stop pulsed during frame 3; a drop first restarts seq at 0.
    bus.TCP_OPEN_ACK = 1'b0;
    tick();
    tick();
    bus.TCP_OPEN_ACK = 1'b1;
    m_seq = 32'd0;
    clear();
    bus.GEN_LEN  = 16'd0;
    bus.GEN_CONT = 1'b1;
    pulse_start();
    wait_cap(13, "cont");
    bus.GEN_STOP = 1'b1;
    tick();
    bus.GEN_STOP = 1'b0;
    wait_idle("cont");
    bus.GEN_CONT = 1'b0;
    for (int f = 0; f < 3; f++) push_frame(0);
    cmp_frames("cont");
    chk("cont frame2 seq lsb", (cap.size() > 4 + 6) ? cap[10] : 8'h00, 8'h01);
    chk("cont frame2 csum", (cap.size() > 11) ? cap[11] : 8'h00, 8'hA4);
    chk("cont gap", (capt.size() > 6) ? capt[6] - capt[5] : -1, 2);

    // Back-pressure for 5 cycles during payload.
    clear();
    bus.GEN_LEN = 16'd10;
    pulse_start();
    wait_cap(8, "bp");
    bus.TCP_TX_FULL = 1'b1;
    repeat (5) tick();
    bus.TCP_TX_FULL = 1'b0;
    wait_idle("bp");
    push_frame(10);
    cmp_frames("bp");
    chk("bp stalled cycles",
        (capt.size() > 0) ? (capt[capt.size()-1] - capt[0] + 1) - cap.size() : -1, 5);

    // Connection drop while the last sequence byte is pending.
    clear();
    bus.GEN_LEN = 16'd5;
    pulse_start();
    wait_cap(3, "drop");
    bus.TCP_OPEN_ACK = 1'b0;
    tick();
    tick();
    chk("drop bytes written", cap.size(), 4);
    chk("drop busy", bus.GEN_BUSY, 0);
    chk("drop frame_cnt", bus.FRAME_CNT, m_cnt);
    bus.TCP_OPEN_ACK = 1'b1;
    m_seq = 32'd0;
    tick();
    clear();
    bus.GEN_LEN = 16'd0;
    pulse_start();
    wait_idle("reopen");
    push_frame(0);
    cmp_frames("reopen");
    chk("reopen seq", (cap.size() >= 5) ? {cap[1], cap[2], cap[3], cap[4]} : 32'hFFFF_FFFF, 0);

    // Start gating: no start without a connection, no restart while busy.
    bus.TCP_OPEN_ACK = 1'b0;
    tick();
    clear();
    pulse_start();
    repeat (5) tick();
    chk("gated writes", cap.size(), 0);
    chk("gated busy", busy_seen, 0);
    bus.TCP_OPEN_ACK = 1'b1;
    m_seq = 32'd0;
    tick();
    clear();
    bus.GEN_LEN = 16'd20;
    pulse_start();
    repeat (8) tick();
    pulse_start();
    wait_idle("restart");
    push_frame(20);
    cmp_frames("restart ignored");

    // Payload longer than 256 bytes wraps the index byte.
    clear();
    bus.GEN_LEN = 16'd300;
    pulse_start();
    wait_idle("wrap");
    push_frame(300);
    cmp_frames("wrap");
    if (cap.size() == 306) begin
      chk("wrap pay255", cap[5 + 255], 8'hFF);
      chk("wrap pay256", cap[5 + 256], 8'h00);
      chk("wrap last pay", cap[304], 8'h2B);
    end else begin
      chk("wrap size", cap.size(), 306);
    end

    // Random lengths under random back-pressure.
    rnd_full = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int len;
      clear();
      len = $urandom_range(0, 40);
      bus.GEN_LEN = 16'(len);
      pulse_start();
      wait_idle("rand");
      push_frame(len);
      cmp_frames($sformatf("rand%0d len%0d", r, len));
    end
    rnd_full = 1'b0;
    bus.TCP_TX_FULL = 1'b0;
    tick();

    // Synchronous reset mid-payload.
    clear();
    bus.GEN_LEN = 16'd50;
    pulse_start();
    wait_cap(10, "rst");
    rst = 1'b1;
    tick();
    chk("rst wr", bus.TCP_TX_WR, 0);
    chk("rst data", bus.TCP_TX_DATA, 0);
    chk("rst busy", bus.GEN_BUSY, 0);
    chk("rst frame_cnt", bus.FRAME_CNT, 0);
    rst = 1'b0;
    n = cap.size();
    repeat (5) tick();
    chk("rst no further writes", cap.size(), n);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
